// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit and sequencing controller for the E stage.
// Latency: result computed at the start edge and held in pend_*_q, committed
// to HI/LO after MULT_CYCLES (mult) or DIV_CYCLES (div) busy cycles.
// Backpressure: MULT_Busy is raised for the whole busy window; the pipeline
// stalls later multdiv-class instructions in D, and any start/mt* presented
// while busy is ignored.
//
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   MD_EN         - valid instruction in E
//   MD_Op         - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO,
//                   7 MTHI, 8 MTLO, 9-15 NONE
//   MD_A, MD_B    - forwarded rs / rt operands
//   MULT_Start    - combinational start pulse (idle + valid mult/div op)
//   MULT_Busy     - registered busy flag
//   MD_RD         - combinational mfhi/mflo read data
//   HI, LO        - architectural HI/LO registers
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,   // legal 1..15
  parameter int unsigned DIV_CYCLES  = 10   // legal 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MD_EN,
  input  logic [3:0]  MD_Op,
  input  logic [31:0] MD_A,
  input  logic [31:0] MD_B,
  output logic        MULT_Start,
  output logic        MULT_Busy,
  output logic [31:0] MD_RD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // ---------------------------------------------------------------------------
  // Operation decode
  // ---------------------------------------------------------------------------
  logic is_mul_op;
  logic is_div_op;
  logic is_start_op;

  assign is_mul_op   = (MD_Op == OP_MULT) || (MD_Op == OP_MULTU);
  assign is_div_op   = (MD_Op == OP_DIV)  || (MD_Op == OP_DIVU);
  assign is_start_op = is_mul_op || is_div_op;

  assign MULT_Start  = MD_EN && (state_q == S_IDLE) && is_start_op;
  assign MULT_Busy   = (state_q == S_BUSY);

  // ---------------------------------------------------------------------------
  // Arithmetic datapath (evaluated every cycle, captured only on MULT_Start)
  // ---------------------------------------------------------------------------
  logic signed [63:0] a_sx, b_sx;
  logic        [63:0] prod_s, prod_u;

  assign a_sx   = {{32{MD_A[31]}}, MD_A};
  assign b_sx   = {{32{MD_B[31]}}, MD_B};
  // Low 64 bits of the sign-extended product are the exact signed product.
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, MD_A} * {32'd0, MD_B};

  logic        div_by_zero;
  logic [31:0] den_u;
  logic [31:0] a_mag, b_mag, b_mag_nz;
  logic [31:0] q_mag, r_mag;
  logic [31:0] q_s, r_s;
  logic [31:0] q_u, r_u;

  assign div_by_zero = (MD_B == 32'd0);

  // Keep the divider's denominator nonzero so it never produces X; the
  // quotient is discarded on divide-by-zero anyway.
  assign den_u = div_by_zero ? 32'd1 : MD_B;
  assign q_u   = MD_A / den_u;
  assign r_u   = MD_A % den_u;

  // Signed divide on magnitudes. 0x80000000 has magnitude 0x80000000 as an
  // unsigned value, so the overflow case -2^31 / -1 falls out as 0x80000000
  // with remainder 0 without a special case.
  assign a_mag    = MD_A[31] ? (32'd0 - MD_A) : MD_A;
  assign b_mag    = MD_B[31] ? (32'd0 - MD_B) : MD_B;
  assign b_mag_nz = div_by_zero ? 32'd1 : b_mag;
  assign q_mag    = a_mag / b_mag_nz;
  assign r_mag    = a_mag % b_mag_nz;
  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign q_s = (MD_A[31] ^ MD_B[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s = MD_A[31] ? (32'd0 - r_mag) : r_mag;

  logic [31:0] res_hi, res_lo;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    unique case (MD_Op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        // Divide by zero commits the current HI/LO back, i.e. no change.
        if (!div_by_zero) begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      OP_DIVU: begin
        if (!div_by_zero) begin
          res_hi = r_u;
          res_lo = q_u;
        end
      end
      default: begin
        res_hi = hi_q;
        res_lo = lo_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (MULT_Start) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          cnt_d     = is_div_op ? DIV_CNT : MULT_CNT;
          state_d   = S_BUSY;
        end else if (MD_EN) begin
          if (MD_Op == OP_MTHI) hi_d = MD_A;
          if (MD_Op == OP_MTLO) lo_d = MD_A;
        end
      end
      S_BUSY: begin
        // The countdown runs regardless of MD_EN: while a multdiv op is
        // stalled in D, E sees bubbles, and freezing here would deadlock.
        // The <= guard keeps an out-of-range count of 0 from wrapping.
        if (cnt_q <= 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign HI = hi_q;
  assign LO = lo_q;

  // Read port ignores MD_EN and busy: during a busy window it returns the
  // value from before the op, since HI/LO only change at commit.
  always_comb begin
    MD_RD = 32'd0;
    if (MD_Op == OP_MFHI) MD_RD = hi_q;
    else if (MD_Op == OP_MFLO) MD_RD = lo_q;
  end

endmodule
